dff_reg: RTL and testbench

- Parameterizable D-type register: a WIDTH-bit data path, optionally pipelined through DEPTH stages, with a clock enable.
- It is the generic storage and retiming primitive used across the design.
- Default configuration (WIDTH=1, DEPTH=1) is a plain single-bit D flip-flop: q takes d on each rising clk edge.

---
 rtl/dff_pkg.sv | 35 +++
 rtl/dff_stage.sv | 35 +++
 rtl/dff_reg.sv | 57 +++++
 tb/tb_dff_reg.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// ============================================================================
// Module  : dff_pkg
// Brief   : Shared constants and elaboration helpers for the dff_reg family.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package dff_pkg;

   localparam int DFF_DEFAULT_WIDTH = 1;
   localparam int DFF_MAX_WIDTH     = 1024;
   localparam int DFF_MAX_DEPTH     = 16;

   // Widest word any instance may carry; reset values are staged through it.
   typedef logic [DFF_MAX_WIDTH-1:0] dff_word_t;

   // Clears every bit above 'width' so a reset value always fits its register.
   function automatic dff_word_t dff_reset_word(input dff_word_t value,
                                                input int unsigned width);
      dff_word_t mask;
      mask = (dff_word_t'(1) << width) - dff_word_t'(1);
      if (width >= DFF_MAX_WIDTH) begin
         mask = '1;
      end
      return value & mask;
   endfunction

   function automatic bit dff_params_ok(input int width, input int depth);
      return (width >= 1) && (width <= DFF_MAX_WIDTH) &&
             (depth >= 1) && (depth <= DFF_MAX_DEPTH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dff_stage.sv
// ============================================================================
// Module  : dff_stage
// Brief   : One WIDTH-bit register with async active-high reset and enable.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dff_stage
   import dff_pkg::*;
#(
   parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VALUE;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/dff_reg.sv
// ============================================================================
// Module  : dff_reg
// Brief   : WIDTH-bit register pipelined through DEPTH enabled stages.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dff_reg
   import dff_pkg::*;
#(
   parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] c_reset_value =
      WIDTH'(dff_reset_word(dff_word_t'(RESET_VALUE), WIDTH));

   if (!dff_params_ok(WIDTH, DEPTH)) begin : g_param_check
      $fatal(1, "dff_reg: WIDTH must be 1..1024 and DEPTH 1..16");
   end

   logic [WIDTH-1:0] w_chain [DEPTH];

   // Stage 0 takes d; every later stage takes its predecessor's output.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] w_stage_d;

      if (i == 0) begin : g_head
         assign w_stage_d = d;
      end else begin : g_link
         assign w_stage_d = w_chain[i-1];
      end

      dff_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (c_reset_value)
      ) u_stage (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .d   (w_stage_d),
         .q   (w_chain[i])
      );
   end

   assign q = w_chain[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_dff_reg.sv
// ============================================================================
// Module  : tb_dff_reg
// Brief   : Directed self-checking bench for a 1x1 and an 8x3 dff_reg.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dff_reg;

   logic       clk = 1'b0;
   logic       rst_a, en_a, d_a, q_a;
   logic       rst_b, en_b;
   logic [7:0] d_b, q_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dff_reg #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_dut_a (
      .clk (clk), .rst (rst_a), .en (en_a), .d (d_a), .q (q_a)
   );

   dff_reg #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_dut_b (
      .clk (clk), .rst (rst_b), .en (en_b), .d (d_b), .q (q_b)
   );

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b1; d_a = 1'b1;
      rst_b = 1'b1; en_b = 1'b1; d_b = 8'hFF;
      tick();
      tick();
      check("a_reset", {7'd0, q_a}, 8'h00);
      check("b_reset", q_b, 8'hA5);

      // ---------------- single-bit flop ----------------
      @(negedge clk);
      rst_a = 1'b0; d_a = 1'b0;
      tick();
      check("a_cap0", {7'd0, q_a}, 8'h00);
      @(negedge clk); d_a = 1'b1;
      tick();
      check("a_cap1", {7'd0, q_a}, 8'h01);

      // async reset between edges
      @(negedge clk); #2;
      rst_a = 1'b1;
      #1;
      check("a_async_rst", {7'd0, q_a}, 8'h00);
      tick();
      check("a_rst_hold1", {7'd0, q_a}, 8'h00);
      tick();
      check("a_rst_hold2", {7'd0, q_a}, 8'h00);
      @(negedge clk); rst_a = 1'b0;
      tick();
      check("a_post_rst", {7'd0, q_a}, 8'h01);

      // enable hold
      @(negedge clk); en_a = 1'b0; d_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("a_en_hold", {7'd0, q_a}, 8'h01);
      end
      @(negedge clk); en_a = 1'b1;
      tick();
      check("a_en_resume", {7'd0, q_a}, 8'h00);

      // reset coincident with a clock edge while d=1
      @(negedge clk); d_a = 1'b1;
      tick();
      check("a_pre_simul", {7'd0, q_a}, 8'h01);
      @(posedge clk);
      rst_a = 1'b1;
      #1;
      check("a_simul_rst", {7'd0, q_a}, 8'h00);
      @(negedge clk); rst_a = 1'b0;

      // ---------------- 8-bit, 3-deep pipeline ----------------
      @(negedge clk);
      rst_b = 1'b0; d_b = 8'h01;
      tick();
      check("b_lat_e1", q_b, 8'hA5);
      @(negedge clk); d_b = 8'h02;
      tick();
      check("b_lat_e2", q_b, 8'hA5);
      @(negedge clk); d_b = 8'h03;
      tick();
      check("b_lat_e3", q_b, 8'h01);
      @(negedge clk); d_b = 8'h04;
      tick();
      check("b_lat_e4", q_b, 8'h02);
      @(negedge clk); d_b = 8'h05;
      tick();
      check("b_lat_e5", q_b, 8'h03);

      // gated edges do not advance the pipeline
      @(negedge clk); en_b = 1'b0; d_b = 8'hFF;
      tick();
      check("b_en_hold1", q_b, 8'h03);
      tick();
      check("b_en_hold2", q_b, 8'h03);
      @(negedge clk); en_b = 1'b1; d_b = 8'h33;
      tick();
      check("b_en_resume", q_b, 8'h04);
      @(negedge clk); d_b = 8'h22;
      tick();
      check("b_fill2", q_b, 8'h05);
      @(negedge clk); d_b = 8'h11;
      tick();
      check("b_fill3", q_b, 8'h33);

      // mid-pipeline reset discards 11/22/33
      @(negedge clk); #2;
      rst_b = 1'b1;
      #1;
      check("b_async_rst", q_b, 8'hA5);
      tick();
      check("b_rst_hold", q_b, 8'hA5);
      @(negedge clk); rst_b = 1'b0; d_b = 8'h00;
      tick();
      check("b_flush1", q_b, 8'hA5);
      tick();
      check("b_flush2", q_b, 8'hA5);
      tick();
      check("b_flush3", q_b, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
